// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
//   Single-port 32-bit data memory model answering a CPU-style handshake.
//   A request seen in IDLE is latched, waits LATENCY cycles, touches the
//   array on the edge that enters RESP and then pulses mem_resp for one cycle.
//
// Parameters
//   DEPTH    words in the backing array (power of two, >= 4)
//   LATENCY  wait cycles before the response (0..15)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   mem_read     read request, held until mem_resp
//   mem_write    write request, held until mem_resp (wins over mem_read)
//   mem_address  byte address, word index = mem_address[log2(DEPTH)+1:2]
//   mem_wdata    lane-aligned write data
//   mem_mbe      write byte-lane enables
//   mem_rdata    read data, non-zero only during a read response
//   mem_resp     one-cycle completion pulse
//   mem_err      (DMEM_RANGE_CHECK_EN only) out-of-range flag, with mem_resp
//
// Build option
//   DMEM_RANGE_CHECK_EN  when defined, addresses at or beyond DEPTH words are
//                        flagged on mem_err, writes are dropped and reads
//                        return 0; otherwise the index wraps modulo DEPTH.
// ---------------------------------------------------------------------------
module cpu_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_mbe,
  output logic [31:0] mem_rdata,
  output logic        mem_resp
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic        mem_err
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = 4;
  localparam logic [CW-1:0] LAT_INIT = CW'(LATENCY);
  localparam bit          ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      mbe_q;
  logic            write_q;
  logic            mem_resp_q;
  logic [31:0]     mem_rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
  logic            mem_err_q;
`endif

  logic [31:0]     mem_q [DEPTH];

  logic            req_c;
  logic [31:0]     acc_addr_c;
  logic [31:0]     acc_wdata_c;
  logic [3:0]      acc_mbe_c;
  logic            acc_write_c;
  logic [AW-1:0]   acc_idx_c;
  logic            acc_oor_c;
  logic [31:0]     cur_word_c;
  logic [31:0]     merged_c;
  logic [31:0]     rd_word_c;
  logic            commit_c;
  logic            unused_c;

  assign req_c = mem_read | mem_write;

  // Access operands: live inputs on the IDLE-exit edge (LATENCY=0), latches otherwise
  always_comb begin
    acc_addr_c  = addr_q;
    acc_wdata_c = wdata_q;
    acc_mbe_c   = mbe_q;
    acc_write_c = write_q;
    if (state_q == IDLE) begin
      acc_addr_c  = mem_address;
      acc_wdata_c = mem_wdata;
      acc_mbe_c   = mem_mbe;
      acc_write_c = mem_write;
    end
  end

  assign acc_idx_c = acc_addr_c[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  assign acc_oor_c = ({2'b00, acc_addr_c[31:2]} >= 32'(DEPTH));
`else
  assign acc_oor_c = 1'b0;
`endif

  // Byte-lane merge of the write data into the current word
  assign cur_word_c = mem_q[acc_idx_c];

  always_comb begin
    merged_c = cur_word_c;
    for (int i = 0; i < 4; i++) begin
      if (acc_mbe_c[i]) merged_c[8*i +: 8] = acc_wdata_c[8*i +: 8];
    end
  end

  assign rd_word_c = acc_oor_c ? 32'h0 : cur_word_c;

  // The edge that enters RESP is the one that touches the array
  assign commit_c = ((state_q == IDLE) && req_c && ZERO_LAT) ||
                    ((state_q == WAIT) && (cnt_q <= CW'(1)));

  // Address bits that never select a word in this configuration
  assign unused_c = ^{acc_addr_c[1:0], acc_addr_c[31:AW+2]};

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mbe_q       <= '0;
      write_q     <= 1'b0;
      mem_resp_q  <= 1'b0;
      mem_rdata_q <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      mem_err_q   <= 1'b0;
`endif
    end else begin
      mem_resp_q  <= 1'b0;
      mem_rdata_q <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      mem_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_c) begin
            addr_q  <= mem_address;
            wdata_q <= mem_wdata;
            mbe_q   <= mem_mbe;
            write_q <= mem_write;
            cnt_q   <= LAT_INIT;
            state_q <= ZERO_LAT ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (commit_c) begin
        mem_resp_q  <= 1'b1;
        mem_rdata_q <= acc_write_c ? 32'h0 : rd_word_c;
`ifdef DMEM_RANGE_CHECK_EN
        mem_err_q   <= acc_oor_c;
`endif
      end
    end
  end

  // Array is never cleared; a reset on the commit edge drops the write
  always_ff @(posedge clk) begin
    if (rst && commit_c && acc_write_c && !acc_oor_c) begin
      mem_q[acc_idx_c] <= merged_c;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign mem_resp  = mem_resp_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign mem_err   = mem_err_q;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder
//   Directed bench for cpu_mem_responder. Two instances share clk/rst:
//   index 0 is built with LATENCY=0, index 1 with LATENCY=2 (DEPTH=1024).
// ---------------------------------------------------------------------------
module tb_cpu_mem_responder;

  localparam int L0 = 0;
  localparam int L2 = 1;

  logic        clk;
  logic        rst;
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  mbe_s   [2];
  logic [31:0] rdata_s [2];
  logic        resp_s  [2];
`ifdef DMEM_RANGE_CHECK_EN
  logic        err_s   [2];
`endif

  int checks;
  int errors;

  cpu_mem_responder #(.DEPTH(1024), .LATENCY(0)) dut_l0 (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (rd_s[0]),
    .mem_write   (wr_s[0]),
    .mem_address (addr_s[0]),
    .mem_wdata   (wdata_s[0]),
    .mem_mbe     (mbe_s[0]),
    .mem_rdata   (rdata_s[0]),
    .mem_resp    (resp_s[0])
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .mem_err     (err_s[0])
`endif
  );

  cpu_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut_l2 (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (rd_s[1]),
    .mem_write   (wr_s[1]),
    .mem_address (addr_s[1]),
    .mem_wdata   (wdata_s[1]),
    .mem_mbe     (mbe_s[1]),
    .mem_rdata   (rdata_s[1]),
    .mem_resp    (resp_s[1])
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .mem_err     (err_s[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    rd_s[sel]    = rd;
    wr_s[sel]    = wr;
    addr_s[sel]  = a;
    wdata_s[sel] = d;
    mbe_s[sel]   = m;
  endtask

  // One transaction: present at a negedge, hold until the response pulse.
  // lat is the number of cycles from the request cycle to the resp cycle,
  // or -1 if no response arrives within the budget.
  task automatic txn(input int sel, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, output int lat,
                     output logic [31:0] rdata, output logic err);
    @(negedge clk);
    drive(sel, rd, wr, a, d, m);
    lat   = -1;
    rdata = 32'h0;
    err   = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_s[sel] === 1'b1) begin
        lat   = k;
        rdata = rdata_s[sel];
`ifdef DMEM_RANGE_CHECK_EN
        err   = err_s[sel];
`endif
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(L0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(L2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (resp_s[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_resp[%0d]: got %b expected 0", s, resp_s[s]);
      end
      checks++;
      if (rdata_s[s] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata[%0d]: got %h expected 00000000", s, rdata_s[s]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_read_latency();
    int lat; logic [31:0] rd; logic er;
    txn(L2, 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, lat, rd, er);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_lat: got %0d expected 3", lat); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 00000000", rd); end
    txn(L2, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, rd, er);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rd_lat: got %0d expected 3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    @(negedge clk);
    checks++;
    if (resp_s[L2] !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got %b expected 0", resp_s[L2]); end
    checks++;
    if (rdata_s[L2] !== 32'h0) begin errors++; $display("FAIL rd_idle_rdata: got %h expected 00000000", rdata_s[L2]); end
  endtask

  task automatic test_write_merge();
    int lat; logic [31:0] rd; logic er;
    txn(L2, 1'b0, 1'b1, 32'h0C, 32'h11223344, 4'hF, lat, rd, er);
    txn(L2, 1'b0, 1'b1, 32'h0C, 32'hAABBCCDD, 4'b0110, lat, rd, er);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL merge_wr_lat: got %0d expected 3", lat); end
    txn(L2, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, lat, rd, er);
    checks++;
    if (rd !== 32'h11BBCC44) begin errors++; $display("FAIL merge_rd: got %h expected 11bbcc44", rd); end
    // mbe=0 still completes but leaves the word alone
    txn(L2, 1'b0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0, lat, rd, er);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL mbe0_lat: got %0d expected 3", lat); end
    txn(L2, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, lat, rd, er);
    checks++;
    if (rd !== 32'h11BBCC44) begin errors++; $display("FAIL mbe0_rd: got %h expected 11bbcc44", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er;
    logic exp_resp; logic [31:0] exp_data; logic prev_resp;
    txn(L0, 1'b0, 1'b1, 32'h04, 32'hA5A50001, 4'hF, lat, rd, er);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL l0_wr_lat: got %0d expected 1", lat); end
    txn(L0, 1'b0, 1'b1, 32'h08, 32'h5A5A0002, 4'hF, lat, rd, er);
    prev_resp = 1'b0;
    // Read held for cycles 0..5: address 0x4, 0x4, 0x8, 0x8, 0x4, 0x4
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_resp = (k == 1) || (k == 3) || (k == 5);
      exp_data = (k == 1 || k == 5) ? 32'hA5A50001 : (k == 3) ? 32'h5A5A0002 : 32'h0;
      checks++;
      if (resp_s[L0] !== exp_resp) begin
        errors++;
        $display("FAIL b2b_resp cyc%0d: got %b expected %b", k, resp_s[L0], exp_resp);
      end
      checks++;
      if (rdata_s[L0] !== exp_data) begin
        errors++;
        $display("FAIL b2b_rdata cyc%0d: got %h expected %h", k, rdata_s[L0], exp_data);
      end
      checks++;
      if (prev_resp === 1'b1 && resp_s[L0] === 1'b1) begin
        errors++;
        $display("FAIL b2b_consecutive cyc%0d: got resp 1 twice expected a gap", k);
      end
      prev_resp = resp_s[L0];
      if (k < 6) drive(L0, 1'b1, 1'b0, (k == 2 || k == 3) ? 32'h08 : 32'h04, 32'h0, 4'h0);
      else       drive(L0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er;
    txn(L2, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, lat, rd, er);
    @(negedge clk);
    drive(L2, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    drive(L2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (resp_s[L2] !== 1'b0) begin
        errors++;
        $display("FAIL abort_resp cyc%0d: got %b expected 0", k, resp_s[L2]);
      end
      @(negedge clk);
    end
    txn(L2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
    checks++;
    if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_rd: got %h expected 12345678", rd); end
  endtask

  task automatic test_both_high();
    int lat; logic [31:0] rd; logic er;
    txn(L2, 1'b0, 1'b1, 32'h0, 32'hCAFEBA00, 4'hF, lat, rd, er);
    txn(L2, 1'b1, 1'b1, 32'h0, 32'h00000005, 4'b0001, lat, rd, er);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL both_lat: got %0d expected 3", lat); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL both_rdata: got %h expected 00000000", rd); end
    txn(L2, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    checks++;
    if (rd !== 32'hCAFEBA05) begin errors++; $display("FAIL both_rd: got %h expected cafeba05", rd); end
  endtask

  task automatic test_range();
    int lat; logic [31:0] rd; logic er;
    txn(L2, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, lat, rd, er);
    txn(L2, 1'b0, 1'b1, 32'h1000, 32'h77777777, 4'hF, lat, rd, er);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL range_wr_lat: got %0d expected 3", lat); end
`ifdef DMEM_RANGE_CHECK_EN
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL range_wr_err: got %b expected 1", er); end
    txn(L2, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    checks++;
    if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL range_word0: got %h expected 0badf00d", rd); end
    checks++;
    if (er !== 1'b0) begin errors++; $display("FAIL range_inrange_err: got %b expected 0", er); end
    txn(L2, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL range_oor_rd: got %h expected 00000000", rd); end
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL range_oor_rd_err: got %b expected 1", er); end
`else
    txn(L2, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
    checks++;
    if (rd !== 32'h77777777) begin errors++; $display("FAIL range_wrap: got %h expected 77777777", rd); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read_latency();
    test_write_merge();
    test_back_to_back();
    test_reset_abort();
    test_both_high();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words in the backing array; power of two, at least 4.
REQ-002 Parameter LATENCY, default 2: wait cycles inserted before the response; legal range 0..15.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port mem_read, input, 1: read request; held high until mem_resp.
REQ-006 Port mem_write, input, 1: write request; held high until mem_resp.
REQ-007 Port mem_address, input, 32: byte address; bits [1:0] ignored, word index = mem_address[log2(DEPTH)+1:2].
REQ-008 Port mem_wdata, input, 32: write data, already byte-lane aligned by the requester.
REQ-009 Port mem_mbe, input, 4: write byte enables; bit i enables byte lane i.
REQ-010 Port mem_rdata, output, 32: read data, valid only while mem_resp is high.
REQ-011 Port mem_resp, output, 1: one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT and RESP, encoded as an enum.
REQ-013 IDLE: when mem_read or mem_write is high, latch address, wdata, mbe and op; load the counter with LATENCY; go to WAIT, or to RESP if LATENCY=0.
REQ-014 WAIT: decrement the counter each cycle; on the edge where counter=1, perform the array access and go to RESP.
REQ-015 LATENCY=0: perform the array access on the IDLE-exit edge.
REQ-016 Latency: a request first seen in IDLE at cycle T SHALL get mem_resp high in exactly cycle T+1+LATENCY.
REQ-017 RESP: mem_resp=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-018 Back-to-back: a request held high in the IDLE cycle after RESP SHALL be accepted as a new transaction; mem_resp is never high in two consecutive cycles.
REQ-019 Inputs SHALL be ignored in WAIT and RESP; the latched transaction completes even if the requester drops or changes its request.
REQ-020 Read: mem_rdata SHALL equal the full latched word; mem_mbe is ignored.
REQ-021 Write: only the lanes enabled in the latched mbe are updated; mbe=4'b0000 is a no-op that still responds; mem_rdata=0 during a write response.
REQ-022 If mem_read and mem_write are both high, the transaction SHALL be a write.
REQ-023 Outside RESP: mem_resp=0 and mem_rdata=0.
REQ-024 A read following a write to the same word SHALL return the merged, written data.

Reset
REQ-025 rst low at a rising edge SHALL force IDLE, counter=0 and all latches=0.
REQ-026 mem_resp=0 and mem_rdata=0 in the cycle after reset.
REQ-027 Reset mid-transaction aborts it; a write not yet committed SHALL NOT reach the array.
REQ-028 Array contents are not cleared by rst and are preloadable by the bench.

Configuration
REQ-029 The feature is compiled in with macro DMEM_RANGE_CHECK_EN.
REQ-030 With DMEM_RANGE_CHECK_EN defined: add output port mem_err, 1 bit, high only together with mem_resp, when mem_address[31:2] >= DEPTH.
REQ-031 With the macro defined, an out-of-range write is suppressed and an out-of-range read returns 0.
REQ-032 Without the macro: no mem_err port, and the index wraps modulo DEPTH (upper address bits ignored).

Verification
REQ-033 LATENCY=2, word 5 preloaded 0xDEADBEEF; read 0x14 asserted at cycle 10 -> mem_resp only in cycle 13 with rdata 0xDEADBEEF.
REQ-034 Word 3=0x11223344; write 0x0C with wdata 0xAABBCCDD and mbe 4'b0110 -> response; then read 0x0C -> 0x11BBCC44.
REQ-035 LATENCY=0, read held high for 6 cycles across two addresses -> resp in cycles 1, 3 and 5 with the correct data; never in consecutive cycles.
REQ-036 Write 0xFFFFFFFF to 0x20 with mbe 4'b1111; rst low during WAIT -> no resp; subsequent read of 0x20 returns the old value.
REQ-037 Macro defined, DEPTH=1024: write to 0x1000 -> resp with mem_err=1 and word 0 unchanged. Macro undefined: the same write updates word 0.
REQ-038 read and write both high, write 0x5 with mbe 4'b0001 to 0x0 -> rdata=0 at resp; byte 0 of word 0 becomes 0x05.
